mainfsm: RTL and testbench
==========================

# mainfsm

Multicycle main control state machine for the ARM-subset CPU. It decodes `Op`/`Funct` from the latched instruction and sequences the shared ALU, memory port and register file across FETCH…WRITEBACK states. It drives the datapath mux selects and the raw write strobes `RegW`, `MemW` and `Branch`. Condition gating of those strobes is applied downstream by the conditional-execution logic.

## Interface
Parameters:
- none (state and mux encodings come from the package)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Op`  in  2  instruction bits [27:26]
- `Funct`  in  6  instruction bits [25:20]; `Funct[5]` = I (immediate), `Funct[0]` = L/S bit
- `MemReady`  in  1  memory access completes this cycle (used only with the macro)
- `IRWrite`  out  1  load instruction register
- `NextPC`  out  1  PC update strobe for sequential fetch
- `AdrSrc`  out  1  0 = PC, 1 = ALU result as memory address
- `ALUSrcA`  out  1  0 = register A, 1 = PC
- `ALUSrcB`  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- `ResultSrc`  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- `ALUOp`  out  1  1 = ALU function from `Funct`, 0 = add
- `RegW`  out  1  raw register write request
- `MemW`  out  1  raw memory write request
- `Branch`  out  1  raw branch request
- `InstrDone`  out  1  one-cycle pulse on the last cycle of each instruction
- `Illegal`  out  1  one-cycle pulse in DECODE when `Op` = 11

## Operation
- Moore machine. Outputs are a pure function of the registered state, plus `MemReady` gating when the macro is defined.
- States and their outputs (unlisted strobes are 0; unlisted selects are don't-care and driven 0):
  - FETCH: `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=0, `ResultSrc`=10, `IRWrite`=1, `NextPC`=1
  - DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10
  - MEMADR: `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=0
  - MEMRD: `AdrSrc`=1
  - MEMWB: `ResultSrc`=01, `RegW`=1
  - MEMWR: `AdrSrc`=1, `MemW`=1
  - EXECR: `ALUSrcA`=0, `ALUSrcB`=00, `ALUOp`=1
  - EXECI: `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=1
  - ALUWB: `ResultSrc`=00, `RegW`=1
  - BRANCH: `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=0, `ResultSrc`=10, `Branch`=1
- Transitions:
  - FETCH→DECODE.
  - DECODE→ `Op`=01: MEMADR; `Op`=00 with `Funct[5]`=0: EXECR; `Op`=00 with `Funct[5]`=1: EXECI; `Op`=10: BRANCH; `Op`=11: FETCH with `Illegal`=1.
  - MEMADR→ `Funct[0]`=1: MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH; BRANCH→FETCH.
- `InstrDone`=1 in MEMWB, MEMWR, ALUWB and BRANCH, and in DECODE when `Op`=11.
- Any unreachable encoding → FETCH on the next edge, with all strobes 0.

## Timing
- Reset low: state = FETCH immediately (asynchronous). All strobes (`IRWrite`, `NextPC`, `RegW`, `MemW`, `Branch`, `InstrDone`, `Illegal`) are forced 0. Selects show FETCH values.
- First FETCH strobe occurs in the first cycle after `reset` rises.
- Reset asserted mid-instruction aborts it. No partial write strobe is emitted after the asynchronous assertion.
- Cycles per instruction, without wait states: branch 3, data-processing 4, store 4, load 5, illegal 2.
- Strobe semantics: each strobe is valid for the whole cycle and is sampled by the datapath at the next rising edge.

## Configuration
- `MAINFSM_MEMWAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold while `MemReady`=0.
  - In FETCH, `IRWrite`/`NextPC` assert only in the cycle where `MemReady`=1.
  - In MEMWR, `MemW` stays high for every held cycle; `InstrDone` asserts only in the `MemReady`=1 cycle.
  - Each wait cycle adds exactly one cycle to the instruction.
- Undefined: `MemReady` is ignored (single-cycle memory) and the port may be left tied 1.

## Structure
- Package `ctrl_pkg` holds:
  - `statetype` enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  - Localparams for the `ALUSrcB` and `ResultSrc` encodings
  - Localparams for the `Op` codes: DP=00, MEM=01, BR=10
- One sub-module, `mainfsm_outdec`: combinational state→control-word decoder, so the output table can be checked in isolation. Next-state logic and the state register stay in `mainfsm`.

## Test plan
- Reset held low for 3 cycles, then released: all strobes 0 during reset; `IRWrite`=`NextPC`=1 in the first cycle after release.
- `Op`=00, `Funct`=6'b101000 (ADDI): state trace FETCH, DECODE, EXECI, ALUWB; `RegW`=1 only in cycle 4 with `ResultSrc`=00; `InstrDone` pulses once.
- `Op`=01, `Funct[0]`=1 (LDR): 5-cycle trace through MEMRD with `AdrSrc`=1; `RegW`=1 with `ResultSrc`=01 in MEMWB.
- `Op`=01, `Funct[0]`=0 (STR) with the macro defined and `MemReady` low for 2 cycles in MEMWR: `MemW` high 3 cycles; `InstrDone` pulses once, on the `MemReady` cycle; instruction takes 6 cycles.
- `Op`=10: `Branch`=1 in cycle 3 with `ALUSrcB`=01; back in FETCH on cycle 4. `Op`=11: `Illegal` and `InstrDone` pulse in DECODE; FETCH follows.
- `reset` asserted asynchronously mid-MEMWB: `RegW` drops within the same cycle; state = FETCH; no writes until release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main controller: state enum, datapath
// select codes, opcode classes and the packed control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } statetype;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] DP  = 2'b00;
    localparam logic [1:0] MEM = 2'b01;
    localparam logic [1:0] BR  = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// Combinational state -> control-word decoder. mem_ready_i is tied high by the
// parent when wait states are not configured.
module mainfsm_outdec
    import ctrl_pkg::*;
(
    input  statetype   state_i,
    input  logic [1:0] op_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.next_pc    = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALU;
                // Op=11 has no datapath phase; it retires here.
                if (op_i == 2'b11) begin
                    ctrl_o.illegal    = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
            end
            MEMADR: ctrl_o.alu_src_b = SRCB_IMM;
            MEMRD:  ctrl_o.adr_src   = 1'b1;
            MEMWB: begin
                ctrl_o.result_src = RES_RDATA;
                ctrl_o.reg_w      = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_w      = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            EXECR: begin
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = 1'b1;
            end
            EXECI: begin
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = 1'b1;
            end
            ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_w      = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.branch     = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM: state register, next-state logic and reset
// gating of strobes. Define MAINFSM_MEMWAIT_EN to honour MemReady wait states.
module mainfsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       InstrDone,
    output logic       Illegal
);

    statetype state_q, state_d;
    ctrl_t    ctrl;
    logic     mem_ok;
    logic     unused_funct;

    assign unused_funct = ^Funct[4:1];

`ifdef MAINFSM_MEMWAIT_EN
    assign mem_ok = MemReady;
`else
    // Single-cycle memory: the port exists only for pin compatibility.
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = mem_ok ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    MEM:     state_d = MEMADR;
                    DP:      state_d = Funct[5] ? EXECI : EXECR;
                    BR:      state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ok ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = mem_ok ? FETCH : MEMWR;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    mainfsm_outdec u_outdec (
        .state_i     (state_q),
        .op_i        (Op),
        .mem_ready_i (mem_ok),
        .ctrl_o      (ctrl)
    );

    // Strobes are masked by reset directly so an abort kills them mid-cycle.
    assign IRWrite   = ctrl.ir_write   & reset;
    assign NextPC    = ctrl.next_pc    & reset;
    assign RegW      = ctrl.reg_w      & reset;
    assign MemW      = ctrl.mem_w      & reset;
    assign Branch    = ctrl.branch     & reset;
    assign InstrDone = ctrl.instr_done & reset;
    assign Illegal   = ctrl.illegal    & reset;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign ALUOp     = ctrl.alu_op;

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: expected per-instruction summaries are queued by
// the stimulus and retired by a monitor on each InstrDone pulse.
module tb_mainfsm;
    import ctrl_pkg::*;

    logic       clk, reset, MemReady;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, InstrDone, Illegal;
    logic [1:0] ALUSrcB, ResultSrc;

    mainfsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int cycles, regw, memw, branch, illegal, aluop, adr1;
        int res_at_regw, regw_cyc, srcb_at_br, srcb_at_alu;
    } exp_t;

    exp_t sb[$];
    int tests = 0, fails = 0, done_cnt = 0;
    int cyc, n_regw, n_memw, n_br, n_ill, n_aluop, n_adr, res_rw, rw_cyc, srcb_br, srcb_alu;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_acc();
        cyc = 0; n_regw = 0; n_memw = 0; n_br = 0; n_ill = 0; n_aluop = 0; n_adr = 0;
        res_rw = -1; rw_cyc = -1; srcb_br = -1; srcb_alu = -1;
    endtask

    // Monitor: accumulate one instruction's activity, compare on InstrDone.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            clear_acc();
        end else begin
            cyc++;
            if (cyc == 1) begin
                chk("fetch_irwrite", int'(IRWrite), 1);
                chk("fetch_nextpc", int'(NextPC), 1);
            end
            if (RegW)   begin n_regw++; res_rw = int'(ResultSrc); rw_cyc = cyc; end
            if (MemW)   n_memw++;
            if (Branch) begin n_br++; srcb_br = int'(ALUSrcB); end
            if (Illegal) n_ill++;
            if (ALUOp)  begin n_aluop++; srcb_alu = int'(ALUSrcB); end
            if (AdrSrc) n_adr++;
            if (InstrDone) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_cycles"}, cyc, e.cycles);
                    chk({e.name, "_regw"}, n_regw, e.regw);
                    chk({e.name, "_memw"}, n_memw, e.memw);
                    chk({e.name, "_branch"}, n_br, e.branch);
                    chk({e.name, "_illegal"}, n_ill, e.illegal);
                    chk({e.name, "_aluop"}, n_aluop, e.aluop);
                    chk({e.name, "_adrsrc"}, n_adr, e.adr1);
                    chk({e.name, "_res_at_regw"}, res_rw, e.res_at_regw);
                    chk({e.name, "_regw_cycle"}, rw_cyc, e.regw_cyc);
                    chk({e.name, "_srcb_branch"}, srcb_br, e.srcb_at_br);
                    chk({e.name, "_srcb_alu"}, srcb_alu, e.srcb_at_alu);
                    $display("[TB] %s retired after %0d cycles", e.name, cyc);
                end
                done_cnt++;
                clear_acc();
            end
        end
    end

    task automatic chk_idle(string nm);
        chk({nm, "_strobes"}, int'({IRWrite, NextPC, RegW, MemW, Branch, InstrDone, Illegal}), 0);
        chk({nm, "_selects"}, int'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), int'(6'b0_1_10_10));
    endtask

    // Issue one instruction at the start of its FETCH cycle; optional MemReady
    // low window of wait_n cycles starting at instruction cycle wait_at.
    task automatic run_instr(exp_t e, logic [1:0] op, logic [5:0] fn, int wait_at, int wait_n);
        int prev, k;
        Op = op; Funct = fn;
        sb.push_back(e);
        prev = done_cnt;
        if (wait_n > 0) begin
            repeat (wait_at - 1) @(posedge clk);
            #1 MemReady = 1'b0;
            repeat (wait_n) @(posedge clk);
            #1 MemReady = 1'b1;
        end
        k = 0;
        while (done_cnt == prev && k < 30) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == prev) chk({e.name, "_timeout"}, 1, 0);
        #1;
    endtask

    function automatic exp_t mk(string n, int c, int rw, int mw, int b, int il, int ao, int ad,
                                int res, int rwc, int sbb, int sba);
        exp_t e;
        e.name = n; e.cycles = c; e.regw = rw; e.memw = mw; e.branch = b; e.illegal = il;
        e.aluop = ao; e.adr1 = ad; e.res_at_regw = res; e.regw_cyc = rwc;
        e.srcb_at_br = sbb; e.srcb_at_alu = sba;
        return e;
    endfunction

    initial begin
        clear_acc();
        MemReady = 1'b1; Op = 2'b00; Funct = 6'b101000;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("reset");
            chk("reset_state", int'(dut.state_q), int'(FETCH));
        end
        @(posedge clk);
        #1 reset = 1'b1;

        //        name    cyc rw mw br il ao ad res rwc sbb sba
        run_instr(mk("ADDI", 4, 1, 0, 0, 0, 1, 0, 0, 4, -1, 1), 2'b00, 6'b101000, 0, 0);
        run_instr(mk("ADD",  4, 1, 0, 0, 0, 1, 0, 0, 4, -1, 0), 2'b00, 6'b001000, 0, 0);
        run_instr(mk("LDR",  5, 1, 0, 0, 0, 0, 1, 1, 5, -1, -1), 2'b01, 6'b011001, 0, 0);
        run_instr(mk("STR",  4, 0, 1, 0, 0, 0, 1, -1, -1, -1, -1), 2'b01, 6'b011000, 0, 0);
        run_instr(mk("B",    3, 0, 0, 1, 0, 0, 0, -1, -1, 1, -1), 2'b10, 6'b000000, 0, 0);
        run_instr(mk("ILL",  2, 0, 0, 0, 1, 0, 0, -1, -1, -1, -1), 2'b11, 6'b000000, 0, 0);
`ifdef MAINFSM_MEMWAIT_EN
        run_instr(mk("STRW", 6, 0, 3, 0, 0, 0, 3, -1, -1, -1, -1), 2'b01, 6'b011000, 4, 2);
`endif

        // Abort a load in MEMWB with an asynchronous reset.
        Op = 2'b01; Funct = 6'b011001;
        repeat (4) @(posedge clk);
        #2;
        chk("memwb_regw_before_abort", int'(RegW), 1);
        reset = 1'b0;
        #1;
        chk("abort_regw", int'(RegW), 0);
        chk("abort_state", int'(dut.state_q), int'(FETCH));
        repeat (2) begin
            @(negedge clk);
            chk_idle("abort_hold");
        end
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr(mk("ADD2", 4, 1, 0, 0, 0, 1, 0, 0, 4, -1, 0), 2'b00, 6'b000100, 0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
